// File: rtl/razor_error_collector.sv
// Razor shadow-latch error collector: turns unmasked lane errors into a one-cycle recovery
// request with holdoff, and keeps sticky status. Define RAZOR_ERR_RATE_EN for the window-rate alarm.
module razor_error_collector #(
  parameter int N_LANES     = 8,
  parameter int HOLDOFF     = 2,
  parameter int CNT_W       = 16,
  parameter int WIN_LOG2    = 10,
  parameter int RATE_THRESH = 4
) (
  input  logic               Clock_Sys,
  input  logic               Reset,
  input  logic [N_LANES-1:0] ErrorIn,
  input  logic [N_LANES-1:0] ErrorMask,
  input  logic               ClearStatus,
  output logic               GlobalError,
  output logic               Recovering,
  output logic [N_LANES-1:0] ErrorSticky,
  output logic [CNT_W-1:0]   ErrorCount,
  output logic               ErrorRateHigh
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLAG    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  state_t             state;
  logic [3:0]         hold_cnt;
  logic [N_LANES-1:0] live_err;
  logic               hit;
  logic               flag_now;

  assign live_err = ErrorIn & ~ErrorMask;
  assign hit      = |live_err;
  assign flag_now = (state == ST_FLAG);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_Sys or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      GlobalError <= 1'b0;
      Recovering  <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state       <= ST_FLAG;
            GlobalError <= 1'b1;
          end
        end
        ST_FLAG: begin
          state       <= ST_HOLDOFF;
          GlobalError <= 1'b0;
          Recovering  <= 1'b1;
          hold_cnt    <= HOLD_LOAD;
        end
        ST_HOLDOFF: begin
          // Hits are ignored here, including on the exit cycle.
          if (hold_cnt == 4'd1) begin
            state      <= ST_IDLE;
            Recovering <= 1'b0;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          GlobalError <= 1'b0;
          Recovering  <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

  // Status logging; a same-cycle clear beats any set or increment.
  always_ff @(posedge Clock_Sys or posedge Reset) begin
    if (Reset) begin
      ErrorSticky <= '0;
      ErrorCount  <= '0;
    end else if (ClearStatus) begin
      ErrorSticky <= '0;
      ErrorCount  <= '0;
    end else begin
      ErrorSticky <= ErrorSticky | live_err;
      if (flag_now && (ErrorCount != '1)) begin
        ErrorCount <= ErrorCount + 1'b1;
      end
    end
  end

`ifdef RAZOR_ERR_RATE_EN
  localparam logic [WIN_LOG2:0] RATE_LIM = (WIN_LOG2+1)'(RATE_THRESH);

  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   ev_cnt;
  logic [WIN_LOG2:0]   ev_total;

  // A FLAG on the wrap cycle still belongs to the closing window.
  assign ev_total = ev_cnt + {{WIN_LOG2{1'b0}}, flag_now};

  always_ff @(posedge Clock_Sys or posedge Reset) begin
    if (Reset) begin
      win_cnt       <= '0;
      ev_cnt        <= '0;
      ErrorRateHigh <= 1'b0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (&win_cnt) begin
        ev_cnt <= '0;
      end else begin
        ev_cnt <= ev_total;
      end
      if (ClearStatus) begin
        ErrorRateHigh <= 1'b0;
      end else if ((&win_cnt) && (ev_total >= RATE_LIM)) begin
        ErrorRateHigh <= 1'b1;
      end
    end
  end
`else
  assign ErrorRateHigh = 1'b0;
`endif

endmodule

// File: tb/tb_razor_error_collector.sv
// Directed bench for razor_error_collector: default instance plus a CNT_W=4 / WIN_LOG2=4 instance.
module tb_razor_error_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr;
  logic [7:0] err_in, err_mask;
  logic       ge, rec, rate;
  logic [7:0] sticky;
  logic [15:0] cnt;

  logic       rst2, clr2;
  logic [7:0] err_in2, mask2;
  logic       ge2, rec2, rate2;
  logic [7:0] sticky2;
  logic [3:0] cnt2;

  int vectors = 0;
  int miscompares = 0;

  razor_error_collector dut (
    .Clock_Sys(clk), .Reset(rst), .ErrorIn(err_in), .ErrorMask(err_mask),
    .ClearStatus(clr), .GlobalError(ge), .Recovering(rec), .ErrorSticky(sticky),
    .ErrorCount(cnt), .ErrorRateHigh(rate)
  );

  razor_error_collector #(.CNT_W(4), .WIN_LOG2(4), .RATE_THRESH(4)) dut2 (
    .Clock_Sys(clk), .Reset(rst2), .ErrorIn(err_in2), .ErrorMask(mask2),
    .ClearStatus(clr2), .GlobalError(ge2), .Recovering(rec2), .ErrorSticky(sticky2),
    .ErrorCount(cnt2), .ErrorRateHigh(rate2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; clr = 1'b0; clr2 = 1'b0;
    err_in = '0; err_mask = '0; err_in2 = '0; mask2 = '0;
    tick(); tick();
    vectors++; if ({ge, rec, rate, sticky, cnt} !== '0) begin miscompares++; $display("FAIL reset_dut: got %h required 0", {ge, rec, rate, sticky, cnt}); end
    vectors++; if ({ge2, rec2, rate2, sticky2, cnt2} !== '0) begin miscompares++; $display("FAIL reset_dut2: got %h required 0", {ge2, rec2, rate2, sticky2, cnt2}); end
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_single_hit();
    err_in = 8'h04;
    vectors++; if (ge !== 1'b0) begin miscompares++; $display("FAIL single_pre_ge: got %b required 0", ge); end
    tick(); err_in = 8'h00;
    vectors++; if (ge !== 1'b1) begin miscompares++; $display("FAIL single_ge: got %b required 1", ge); end
    vectors++; if (sticky !== 8'h04) begin miscompares++; $display("FAIL single_sticky: got %h required 04", sticky); end
    vectors++; if (rec !== 1'b0) begin miscompares++; $display("FAIL single_rec_flag: got %b required 0", rec); end
    tick();
    vectors++; if ({ge, rec} !== 2'b01) begin miscompares++; $display("FAIL single_hold1: got ge,rec=%b required 01", {ge, rec}); end
    vectors++; if (cnt !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d required 1", cnt); end
    tick();
    vectors++; if ({ge, rec} !== 2'b01) begin miscompares++; $display("FAIL single_hold2: got ge,rec=%b required 01", {ge, rec}); end
    tick();
    vectors++; if ({ge, rec} !== 2'b00) begin miscompares++; $display("FAIL single_idle: got ge,rec=%b required 00", {ge, rec}); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    clr = 1'b1; tick(); clr = 1'b0;
    vectors++; if ({sticky, cnt} !== '0) begin miscompares++; $display("FAIL b2b_clear: got %h required 0", {sticky, cnt}); end
    err_in = 8'hFF;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ge === 1'b1) pulses++;
      vectors++; if (ge !== ((i % 4) == 0)) begin miscompares++; $display("FAIL b2b_ge[%0d]: got %b required %b", i, ge, ((i % 4) == 0)); end
    end
    err_in = 8'h00;
    repeat (4) tick();
    vectors++; if (pulses != 5) begin miscompares++; $display("FAIL b2b_pulses: got %0d required 5", pulses); end
    vectors++; if (cnt !== 16'd5) begin miscompares++; $display("FAIL b2b_count: got %0d required 5", cnt); end
    vectors++; if (sticky !== 8'hFF) begin miscompares++; $display("FAIL b2b_sticky: got %h required ff", sticky); end
  endtask

  task automatic test_mask();
    clr = 1'b1; tick(); clr = 1'b0;
    err_mask = 8'h01; err_in = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ge !== 1'b0) begin miscompares++; $display("FAIL mask_ge[%0d]: got %b required 0", i, ge); end
    end
    vectors++; if (sticky !== 8'h00) begin miscompares++; $display("FAIL mask_sticky: got %h required 00", sticky); end
    err_in = 8'h02; tick(); err_in = 8'h00;
    vectors++; if (ge !== 1'b1) begin miscompares++; $display("FAIL mask_lane1_ge: got %b required 1", ge); end
    vectors++; if (sticky !== 8'h02) begin miscompares++; $display("FAIL mask_lane1_sticky: got %h required 02", sticky); end
    repeat (4) tick();
    // Unmasking and raising the lane in the same cycle must be honoured at once.
    err_mask = 8'h00; err_in = 8'h01; tick(); err_in = 8'h00;
    vectors++; if (ge !== 1'b1) begin miscompares++; $display("FAIL unmask_ge: got %b required 1", ge); end
    vectors++; if (sticky !== 8'h03) begin miscompares++; $display("FAIL unmask_sticky: got %h required 03", sticky); end
    repeat (4) tick();
  endtask

  task automatic test_clear_priority();
    clr = 1'b1; err_in = 8'h08; tick(); err_in = 8'h00;
    vectors++; if (ge !== 1'b1) begin miscompares++; $display("FAIL clr_fsm_ge: got %b required 1", ge); end
    vectors++; if (sticky !== 8'h00) begin miscompares++; $display("FAIL clr_sticky: got %h required 00", sticky); end
    tick(); clr = 1'b0;
    vectors++; if (rec !== 1'b1) begin miscompares++; $display("FAIL clr_fsm_rec: got %b required 1", rec); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL clr_count: got %0d required 0", cnt); end
    repeat (3) tick();
  endtask

  task automatic test_reset_holdoff();
    err_in = 8'h04; tick(); err_in = 8'h00; tick();
    vectors++; if (rec !== 1'b1) begin miscompares++; $display("FAIL rsth_pre_rec: got %b required 1", rec); end
    rst = 1'b1; #1;
    vectors++; if ({ge, rec, rate, sticky, cnt} !== '0) begin miscompares++; $display("FAIL rsth_async: got %h required 0", {ge, rec, rate, sticky, cnt}); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if ({ge, rec} !== 2'b00) begin miscompares++; $display("FAIL rsth_post[%0d]: got ge,rec=%b required 00", i, {ge, rec}); end
    end
    rst = 1'b1; #2; rst = 1'b0; err_in = 8'h04;
    tick(); err_in = 8'h00;
    vectors++; if (ge !== 1'b1) begin miscompares++; $display("FAIL rst_first_hit: got %b required 1", ge); end
    repeat (4) tick();
  endtask

  task automatic test_rate();
    int pulses;
    logic exp_rate;
`ifdef RAZOR_ERR_RATE_EN
    exp_rate = 1'b1;
`else
    exp_rate = 1'b0;
`endif
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      err_in2 = (i < 9) ? 8'hFF : 8'h00;
      tick();
      if (ge2 === 1'b1) pulses++;
    end
    vectors++; if (pulses != 3) begin miscompares++; $display("FAIL rate_w1_pulses: got %0d required 3", pulses); end
    vectors++; if (rate2 !== 1'b0) begin miscompares++; $display("FAIL rate_three: got %b required 0", rate2); end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      err_in2 = (i < 13) ? 8'hFF : 8'h00;
      tick();
      if (ge2 === 1'b1) pulses++;
      if (i == 14) begin
        vectors++; if (rate2 !== 1'b0) begin miscompares++; $display("FAIL rate_prewrap: got %b required 0", rate2); end
      end
    end
    vectors++; if (pulses != 4) begin miscompares++; $display("FAIL rate_w2_pulses: got %0d required 4", pulses); end
    vectors++; if (rate2 !== exp_rate) begin miscompares++; $display("FAIL rate_four: got %b required %b", rate2, exp_rate); end
  endtask

  task automatic test_saturate();
    logic found;
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    vectors++; if ({rate2, cnt2} !== 5'd0) begin miscompares++; $display("FAIL sat_clear: got %h required 0", {rate2, cnt2}); end
    err_in2 = 8'hFF;
    repeat (80) tick();
    vectors++; if (cnt2 !== 4'hF) begin miscompares++; $display("FAIL sat_count: got %h required f", cnt2); end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (ge2 === 1'b1) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL sat_wait_flag: got no GlobalError within 8 cycles required one"); end
    clr2 = 1'b1; err_in2 = 8'h00; tick(); clr2 = 1'b0;
    vectors++; if (cnt2 !== 4'h0) begin miscompares++; $display("FAIL sat_clear_on_flag: got %h required 0", cnt2); end
    vectors++; if (rate2 !== 1'b0) begin miscompares++; $display("FAIL sat_rate_clear: got %b required 0", rate2); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_mask();
    test_clear_priority();
    test_reset_holdoff();
    test_rate();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/razor_error_collector.md
RAZOR_ERROR_COLLECTOR -- requirements
Module: razor_error_collector

Interface
REQ-001 Parameter N_LANES, 8, number of razor shadow-latch error inputs (1..32).
REQ-002 Parameter HOLDOFF, 2, cycles of new-error masking after GlobalError issues (1..15).
REQ-003 Parameter CNT_W, 16, ErrorCount width.
REQ-004 Parameter WIN_LOG2, 10, log2 of rate-monitor window length in cycles.
REQ-005 Parameter RATE_THRESH, 4, per-window event count that raises ErrorRateHigh.
REQ-006 Clock_Sys  input  1  system clock; all state rises on its posedge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 ErrorIn  input  N_LANES  per-lane razor error flags, sampled each cycle.
REQ-009 ErrorMask  input  N_LANES  1 = lane ignored.
REQ-010 ClearStatus  input  1  synchronous clear of ErrorSticky, ErrorCount, ErrorRateHigh.
REQ-011 GlobalError  output  1  registered one-cycle recovery request to the clock manager.
REQ-012 Recovering  output  1  high while in HOLDOFF state.
REQ-013 ErrorSticky  output  N_LANES  per-lane sticky log of unmasked errors.
REQ-014 ErrorCount  output  CNT_W  saturating count of issued GlobalError pulses.
REQ-015 ErrorRateHigh  output  1  sticky window-rate alarm (RAZOR_ERR_RATE_EN only).

Function
REQ-016 Hit = OR over (ErrorIn & ~ErrorMask), evaluated combinationally each cycle.
REQ-017 FSM states IDLE, FLAG, HOLDOFF; reset state IDLE.
REQ-018 IDLE: Hit=1 -> FLAG next cycle; else stay.
REQ-019 FLAG: GlobalError=1 for exactly this one cycle (one cycle after Hit); unconditionally -> HOLDOFF with counter loaded to HOLDOFF.
REQ-020 HOLDOFF: Recovering=1; counter decrements per cycle; Hit ignored for FSM; at counter 1 -> IDLE.
REQ-021 Hit arriving in the cycle HOLDOFF exits to IDLE is ignored; the next Hit in IDLE is honoured.
REQ-022 Minimum GlobalError spacing = HOLDOFF+2 cycles under continuous Hit.
REQ-023 ErrorSticky[i] sets on any cycle (any state) ErrorIn[i]&~ErrorMask[i]=1; clears only via ClearStatus or Reset.
REQ-024 ErrorCount increments on each FLAG cycle; saturates at all-ones, no wrap.
REQ-025 ClearStatus coinciding with a set/increment event: clear wins; that event is not logged or counted.
REQ-026 ClearStatus does not affect FSM, GlobalError, or Recovering.
REQ-027 ErrorMask changes take effect on the same cycle's Hit evaluation.

Reset
REQ-028 Reset asserted: immediately GlobalError=0, Recovering=0, ErrorSticky=0, ErrorCount=0, ErrorRateHigh=0, FSM=IDLE, all counters 0.
REQ-029 Reset mid-HOLDOFF or in FLAG aborts the sequence; no GlobalError after deassertion until a fresh Hit.
REQ-030 First Hit can be sampled on the first posedge after Reset deasserts.

Configuration
REQ-031 Macro RAZOR_ERR_RATE_EN defined: free-running WIN_LOG2-bit window counter plus event counter; at window wrap (counter all-ones), ErrorRateHigh sets if events in that window (including a FLAG on the wrap cycle) >= RATE_THRESH; event counter restarts at 0; ErrorRateHigh sticky until ClearStatus/Reset.
REQ-032 Macro undefined: no window logic instantiated; ErrorRateHigh tied 0; all other behaviour identical.

Verification
REQ-033 Reset, ErrorIn=8'h04 one cycle, mask 0 -> GlobalError pulse exactly 1 cycle later, ErrorSticky=8'h04, ErrorCount=1, Recovering high 2 cycles after pulse.
REQ-034 ErrorIn=8'hFF held 20 cycles, HOLDOFF=2 -> GlobalError pulses every 4 cycles (5 pulses), ErrorCount=5.
REQ-035 ErrorMask=8'h01, ErrorIn=8'h01 -> no GlobalError, ErrorSticky=0; then ErrorIn=8'h02 -> pulse, ErrorSticky=8'h02.
REQ-036 Reset asserted in HOLDOFF cycle 1 -> all outputs 0 asynchronously, no pulse after release with ErrorIn=0.
REQ-037 CNT_W=4, 20 events -> ErrorCount holds 4'hF; ClearStatus same cycle as a FLAG -> ErrorCount=0.
REQ-038 RAZOR_ERR_RATE_EN, WIN_LOG2=4, RATE_THRESH=4: 4 events in one 16-cycle window -> ErrorRateHigh=1 after wrap; 3 events -> stays 0.
